tx_point_test: RTL and testbench
================================

TX_POINT_TEST -- requirements
Module: tx_point_test

Interface
REQ-001 SHALL have parameter PATTERN_CYCLES, default 128, number of cycles the pattern generator runs per test.
REQ-002 SHALL have one clock and synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have i_en in 1: test enable, driven by link-speed controller o_point_test_en.
REQ-004 SHALL have i_mainband_or_valtrain in 1: 1 = mainband data-lane test, 0 = valid-lane (VALTRAIN) test.
REQ-005 SHALL have i_lfsr_or_perlane in 1: 1 = LFSR pattern, 0 = per-lane ID pattern.
REQ-006 SHALL have i_sideband_message in 4 and i_rx_valid in 1: received sideband message code, qualified by i_rx_valid.
REQ-007 SHALL have i_sideband_data in 16: per-lane pass bits carried with RESULT_RESP.
REQ-008 SHALL have o_sideband_message out 4 and o_valid_tx out 1: message to transmit, plus a one-cycle send strobe.
REQ-009 SHALL have o_pattern_en out 1 and o_pattern_type out 1: pattern generator run, and the latched i_lfsr_or_perlane.
REQ-010 SHALL have o_lanes_result out 16 and o_test_ack out 1: per-lane result and test complete, consumed by linkspeed_tx.

Function
REQ-011 SHALL implement states IDLE, START, LFSR_CLR, PATTERN, RESULT, END, DONE.
REQ-012 SHALL treat an input message as received only when i_rx_valid=1 in the same cycle; codes not expected in the current state SHALL be ignored.
REQ-013 IDLE->START when i_en=1.
- On the transition: send START_REQ (code 1).
- Latch i_mainband_or_valtrain and i_lfsr_or_perlane.
REQ-014 START->LFSR_CLR on START_RESP (2); on the transition, send LFSR_CLR_REQ (3).
REQ-015 LFSR_CLR->PATTERN on LFSR_CLR_RESP (4).
- On the transition, clear the cycle counter.
- o_pattern_en=1 from the first PATTERN cycle.
REQ-016 PATTERN SHALL last exactly PATTERN_CYCLES cycles, then go to RESULT.
- o_pattern_en drops the cycle RESULT is entered.
- On the transition, send RESULT_REQ (5).
- Counter width SHALL be clog2(PATTERN_CYCLES+1).
REQ-017 RESULT->END on RESULT_RESP (6); in that cycle latch o_lanes_result:
- Mainband: i_sideband_data[15:0].
- Valtrain: {16{i_sideband_data[0]}}.
- Send END_REQ (7) on the transition.
REQ-018 END->DONE on END_RESP (8).
REQ-019 In DONE: o_test_ack=1 and o_lanes_result held until i_en=0, then IDLE.
REQ-020 o_valid_tx SHALL pulse exactly one cycle, registered, coincident with the first cycle o_sideband_message holds the new code.
REQ-021 o_sideband_message SHALL hold the last sent code until the next send, and SHALL be 0 in IDLE.
REQ-022 i_en=0 in any state SHALL go to IDLE next cycle. In that case:
- Clear o_pattern_en, o_test_ack, o_valid_tx.
- o_lanes_result is retained.
REQ-023 If a response and i_en=0 arrive in the same cycle, i_en=0 SHALL win.
REQ-024 A duplicate response in a later state SHALL NOT cause a resend or state change.

Reset
REQ-025 With rst=1 at a clk edge, all of the following SHALL be 0 on that edge, irrespective of other inputs:
- state=IDLE, counter.
- o_sideband_message, o_valid_tx, o_pattern_en, o_pattern_type, o_lanes_result, o_test_ack.
REQ-026 Reset asserted mid-test SHALL abort without emitting any further sideband message.

Structure
REQ-027 Message codes 1..8 and the state encoding SHALL live in a shared point-test package, reused by the RX-side partner block.
REQ-028 The pattern cycle counter SHALL be a sub-module, pt_cycle_counter (clear, enable, terminal-count output).

Verification
REQ-029 Full mainband pass, PATTERN_CYCLES=128:
- Stimulus: i_en=1; responses 2, 4, 6 with data 16'hFFFF, then 8.
- Response: four o_valid_tx pulses with codes 1, 3, 5, 7; o_pattern_en high exactly 128 cycles; o_test_ack=1; o_lanes_result=16'hFFFF.
REQ-030 Valtrain test, RESULT_RESP data 16'h0000 -> o_lanes_result=16'h0000; same with data 16'h0001 -> 16'hFFFF.
REQ-031 Partial result: data 16'h00FF -> o_lanes_result=16'h00FF and o_test_ack=1.
REQ-032 Abort mid-PATTERN:
- Stimulus: i_en=0 at pattern cycle 50.
- Response: IDLE next cycle, o_pattern_en=0, no further o_valid_tx; re-enable restarts with code 1.
REQ-033 Response code 6 sent in START, and code 2 sent without i_rx_valid, SHALL both be ignored (state stays START).
REQ-034 rst=1 in RESULT -> all outputs 0 next cycle; no o_valid_tx until a new i_en rising.

Source files
------------

// File: rtl/tx_point_test_pkg.sv
// Shared point-test definitions: sideband message codes, FSM state
// encoding and lane-result helper, common to the TX and RX partners.
package tx_point_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LFSR_CLR,
    ST_PATTERN,
    ST_RESULT,
    ST_END,
    ST_DONE
  } pt_state_e;

  localparam logic [3:0] MSG_NONE          = 4'd0;
  localparam logic [3:0] MSG_START_REQ     = 4'd1;
  localparam logic [3:0] MSG_START_RESP    = 4'd2;
  localparam logic [3:0] MSG_LFSR_CLR_REQ  = 4'd3;
  localparam logic [3:0] MSG_LFSR_CLR_RESP = 4'd4;
  localparam logic [3:0] MSG_RESULT_REQ    = 4'd5;
  localparam logic [3:0] MSG_RESULT_RESP   = 4'd6;
  localparam logic [3:0] MSG_END_REQ       = 4'd7;
  localparam logic [3:0] MSG_END_RESP      = 4'd8;

  // Valid-lane training reports a single pass bit that
  // stands for every lane.
  function automatic logic [15:0] pt_lane_result(
    input logic        mainband,
    input logic [15:0] data
  );
    return mainband ? data : {16{data[0]}};
  endfunction

endpackage

// File: rtl/tx_point_test_cycle_counter.sv
// Pattern cycle counter: sync clear, count enable, terminal count
// (tc) high while the count equals MAX-1.
module pt_cycle_counter #(
  parameter int unsigned MAX = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/tx_point_test.sv
// TX-side point test sequencer: sideband handshake, pattern window,
// lane result capture. Ports: clk/rst, enable/mode in, sideband
// rx/tx, pattern run/type, lane result and test ack out.
module tx_point_test
  import tx_point_test_pkg::*;
#(
  parameter int unsigned PATTERN_CYCLES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_mainband_or_valtrain,
  input  logic        i_lfsr_or_perlane,
  input  logic [3:0]  i_sideband_message,
  input  logic        i_rx_valid,
  input  logic [15:0] i_sideband_data,
  output logic [3:0]  o_sideband_message,
  output logic        o_valid_tx,
  output logic        o_pattern_en,
  output logic        o_pattern_type,
  output logic [15:0] o_lanes_result,
  output logic        o_test_ack
);

  pt_state_e   state;
  pt_state_e   state_n;
  logic        en_q;
  logic        mode_q;
  logic        mode_n;
  logic [3:0]  msg_n;
  logic        valid_n;
  logic        pen_n;
  logic        ptype_n;
  logic [15:0] res_n;
  logic        ack_n;
  logic        cnt_clr;
  logic        cnt_tc;

  pt_cycle_counter #(
    .MAX (PATTERN_CYCLES)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (state == ST_PATTERN),
    .tc  (cnt_tc)
  );

  // Start needs a fresh enable: a reset with i_en held
  // high must not kick off a new test by itself.
  always_ff @(posedge clk) begin
    en_q <= i_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      mode_q             <= 1'b0;
      o_sideband_message <= MSG_NONE;
      o_valid_tx         <= 1'b0;
      o_pattern_en       <= 1'b0;
      o_pattern_type     <= 1'b0;
      o_lanes_result     <= '0;
      o_test_ack         <= 1'b0;
    end else begin
      state              <= state_n;
      mode_q             <= mode_n;
      o_sideband_message <= msg_n;
      o_valid_tx         <= valid_n;
      o_pattern_en       <= pen_n;
      o_pattern_type     <= ptype_n;
      o_lanes_result     <= res_n;
      o_test_ack         <= ack_n;
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    msg_n   = o_sideband_message;
    valid_n = 1'b0;
    pen_n   = o_pattern_en;
    ptype_n = o_pattern_type;
    res_n   = o_lanes_result;
    ack_n   = o_test_ack;
    cnt_clr = 1'b0;
    if (!i_en) begin
      state_n = ST_IDLE;
      msg_n   = MSG_NONE;
      pen_n   = 1'b0;
      ack_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!en_q) begin
            state_n = ST_START;
            msg_n   = MSG_START_REQ;
            valid_n = 1'b1;
            mode_n  = i_mainband_or_valtrain;
            ptype_n = i_lfsr_or_perlane;
          end
        end
        ST_START: begin
          if (i_rx_valid &&
              i_sideband_message == MSG_START_RESP) begin
            state_n = ST_LFSR_CLR;
            msg_n   = MSG_LFSR_CLR_REQ;
            valid_n = 1'b1;
          end
        end
        ST_LFSR_CLR: begin
          if (i_rx_valid &&
              i_sideband_message == MSG_LFSR_CLR_RESP) begin
            state_n = ST_PATTERN;
            cnt_clr = 1'b1;
            pen_n   = 1'b1;
          end
        end
        ST_PATTERN: begin
          if (cnt_tc) begin
            state_n = ST_RESULT;
            pen_n   = 1'b0;
            msg_n   = MSG_RESULT_REQ;
            valid_n = 1'b1;
          end
        end
        ST_RESULT: begin
          if (i_rx_valid &&
              i_sideband_message == MSG_RESULT_RESP) begin
            state_n = ST_END;
            res_n   = pt_lane_result(mode_q, i_sideband_data);
            msg_n   = MSG_END_REQ;
            valid_n = 1'b1;
          end
        end
        ST_END: begin
          if (i_rx_valid &&
              i_sideband_message == MSG_END_RESP) begin
            state_n = ST_DONE;
            ack_n   = 1'b1;
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_point_test.sv
// Randomized + directed bench for tx_point_test against a
// transaction-level reference model of the point-test handshake.
module tb_tx_point_test;

  localparam int PC = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_mb;
  logic        i_lfsr;
  logic [3:0]  i_msg;
  logic        i_rxv;
  logic [15:0] i_data;
  logic [3:0]  o_msg;
  logic        o_valid;
  logic        o_pen;
  logic        o_ptype;
  logic [15:0] o_res;
  logic        o_ack;

  tx_point_test #(.PATTERN_CYCLES(PC)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_en                   (i_en),
    .i_mainband_or_valtrain (i_mb),
    .i_lfsr_or_perlane      (i_lfsr),
    .i_sideband_message     (i_msg),
    .i_rx_valid             (i_rxv),
    .i_sideband_data        (i_data),
    .o_sideband_message     (o_msg),
    .o_valid_tx             (o_valid),
    .o_pattern_en           (o_pen),
    .o_pattern_type         (o_ptype),
    .o_lanes_result         (o_res),
    .o_test_ack             (o_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 await START_RESP,
  // 2 await LFSR_CLR_RESP, 3 pattern window,
  // 4 await RESULT_RESP, 5 await END_RESP, 6 done.
  int          m_phase = 0;
  int          m_left = 0;
  bit          m_en_prev = 0;
  bit          m_mode = 0;
  logic [3:0]  m_msg = 0;
  bit          m_valid = 0;
  bit          m_pen = 0;
  bit          m_ptype = 0;
  logic [15:0] m_res = 0;
  bit          m_ack = 0;

  int sent_q[$];
  int pen_cycles = 0;

  function automatic int want(int ph);
    case (ph)
      1: return 2;
      2: return 4;
      4: return 6;
      5: return 8;
      default: return -1;
    endcase
  endfunction

  task automatic send(int c);
    m_msg   = 4'(c);
    m_valid = 1;
  endtask

  task automatic model_update();
    bit hit;
    m_valid = 0;
    hit = i_rxv && (int'(i_msg) == want(m_phase));
    if (rst) begin
      m_phase = 0;
      m_msg = 0;
      m_pen = 0;
      m_ptype = 0;
      m_res = 0;
      m_ack = 0;
      m_mode = 0;
    end else if (!i_en) begin
      m_phase = 0;
      m_msg = 0;
      m_pen = 0;
      m_ack = 0;
    end else begin
      case (m_phase)
        0: if (!m_en_prev) begin
          m_phase = 1;
          send(1);
          m_mode = i_mb;
          m_ptype = i_lfsr;
        end
        1: if (hit) begin
          m_phase = 2;
          send(3);
        end
        2: if (hit) begin
          m_phase = 3;
          m_left = PC;
          m_pen = 1;
        end
        3: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 4;
            m_pen = 0;
            send(5);
          end
        end
        4: if (hit) begin
          if (m_mode) m_res = i_data;
          else m_res = i_data[0] ? 16'hFFFF : 16'h0000;
          m_phase = 5;
          send(7);
        end
        5: if (hit) begin
          m_phase = 6;
          m_ack = 1;
        end
        default: ;
      endcase
    end
    m_en_prev = i_en;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("msg", o_msg, m_msg);
    chk("valid", o_valid, m_valid);
    chk("pen", o_pen, m_pen);
    chk("ptype", o_ptype, m_ptype);
    chk("res", o_res, m_res);
    chk("ack", o_ack, m_ack);
    if (o_valid) sent_q.push_back(int'(o_msg));
    if (o_pen) pen_cycles++;
  endtask

  task automatic drive(bit en, bit rxv, int code,
                       logic [15:0] data);
    i_en   = en;
    i_rxv  = rxv;
    i_msg  = 4'(code);
    i_data = data;
    step();
  endtask

  task automatic do_reset();
    rst = 1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst = 0;
  endtask

  task automatic to_pattern();
    drive(1, 0, 0, 0);
    drive(1, 1, 2, 0);
    drive(1, 1, 4, 0);
  endtask

  task automatic finish_pattern();
    for (int g = 0; g < PC + 4 && m_phase == 3; g++)
      drive(1, 0, 0, 0);
    chk("reach_result", m_phase, 4);
  endtask

  task automatic full_test(bit mb, logic [15:0] data,
                           logic [15:0] exp_res);
    i_mb = mb;
    i_lfsr = 1'($urandom);
    sent_q.delete();
    pen_cycles = 0;
    to_pattern();
    finish_pattern();
    drive(1, 1, 6, data);
    drive(1, 1, 8, 0);
    drive(1, 0, 0, 0);
    chk("done_ack", o_ack, 1);
    chk("done_res", o_res, exp_res);
    chk("pen_cycles", pen_cycles, PC);
    chk("n_sent", sent_q.size(), 4);
    for (int k = 0; k < 4 && k < sent_q.size(); k++)
      chk("sent_code", sent_q[k], 2 * k + 1);
    drive(0, 0, 0, 0);
    chk("idle_msg", o_msg, 0);
  endtask

  initial begin
    rst = 1;
    i_en = 0;
    i_mb = 0;
    i_lfsr = 0;
    i_msg = 0;
    i_rxv = 0;
    i_data = 0;
    do_reset();
    chk("rst_msg", o_msg, 0);
    chk("rst_res", o_res, 0);
    chk("rst_ack", o_ack, 0);

    full_test(1, 16'hFFFF, 16'hFFFF);
    full_test(0, 16'h0000, 16'h0000);
    full_test(0, 16'h0001, 16'hFFFF);
    full_test(1, 16'h00FF, 16'h00FF);

    // abort in pattern cycle 50
    sent_q.delete();
    pen_cycles = 0;
    to_pattern();
    for (int k = 0; k < 49; k++) drive(1, 0, 0, 0);
    chk("abort_pcnt", pen_cycles, 50);
    drive(0, 0, 0, 0);
    chk("abort_pen", o_pen, 0);
    chk("abort_msg", o_msg, 0);
    for (int k = 0; k < 200; k++) drive(0, 1, 6, 0);
    chk("abort_sent", sent_q.size(), 2);
    drive(1, 0, 0, 0);
    chk("restart_v", o_valid, 1);
    chk("restart_c", o_msg, 1);

    // stray responses in START
    drive(1, 1, 6, 16'hFFFF);
    drive(1, 0, 2, 0);
    drive(1, 1, 8, 0);
    chk("stray_msg", o_msg, 1);
    chk("stray_ph", m_phase, 1);
    drive(1, 1, 2, 0);
    chk("start_ok", o_msg, 3);
    drive(1, 1, 2, 0);
    chk("dup_valid", o_valid, 0);

    // reset in RESULT with enable held high
    drive(1, 1, 4, 0);
    finish_pattern();
    sent_q.delete();
    rst = 1;
    drive(1, 1, 6, 16'hAAAA);
    rst = 0;
    chk("rst_mid_msg", o_msg, 0);
    chk("rst_mid_res", o_res, 0);
    for (int k = 0; k < 10; k++) drive(1, 1, 6, 0);
    chk("rst_mid_sent", sent_q.size(), 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("rst_restart", o_msg, 1);
    drive(0, 0, 0, 0);

    // randomized handshakes, aborts and resets
    for (int c = 0; c < 12000; c++) begin
      int code;
      bit en;
      rst = ($urandom_range(0, 399) == 0);
      en = ($urandom_range(0, 299) != 0);
      if (m_phase == 0 && $urandom_range(0, 3) == 0) en = 0;
      if ($urandom_range(0, 9) < 4 && want(m_phase) > 0)
        code = want(m_phase);
      else
        code = int'($urandom_range(0, 15));
      i_mb = 1'($urandom);
      i_lfsr = 1'($urandom);
      drive(en, ($urandom_range(0, 9) < 7), code,
            16'($urandom));
      rst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
